// File: rtl/inv_mix_columns_ctrl.sv
// Column-serial AES InvMixColumns sequencer with AddRoundKey fused in; shares one column unit across RUN cycles.
// Latency: 4/COLS_PER_CYCLE+1 edges from acceptance to out_valid (1 edge when InvMixColumns is bypassed).
// Backpressure: one transfer in flight; in_ready only in IDLE, result holds in DONE until out_ready.
module inv_mix_columns_ctrl #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic [0:127] in_key,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("inv_mix_columns_ctrl: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [0:127] work;
  logic [0:127] work_next;
  logic [1:0]   cnt;
  logic [2:0]   cnt_sum;
  logic         bypass_q;

  // Multiply by x in GF(2^8), reducing with 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // InvMixColumns on one column; byte 0 of the column sits in bits [31:24].
  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0]  b   [4];
    logic [7:0]  m9  [4];
    logic [7:0]  m11 [4];
    logic [7:0]  m13 [4];
    logic [7:0]  m14 [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      b[i]   = col[31-8*i -: 8];
      x2     = xtime(b[i]);
      x4     = xtime(x2);
      x8     = xtime(x4);
      m9[i]  = x8 ^ b[i];
      m11[i] = x8 ^ x2 ^ b[i];
      m13[i] = x8 ^ x4 ^ b[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = m14[r] ^ m11[2'(r+1)] ^ m13[2'(r+2)] ^ m9[2'(r+3)];
    end
    return res;
  endfunction

  // The carry out of the column counter marks the cycle that handles column 3.
  assign cnt_sum  = {1'b0, cnt} + 3'(COLS_PER_CYCLE);
  assign in_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  // Transform the columns selected by the counter this cycle; others pass through.
  always_comb begin
    logic [1:0] idx;
    idx       = cnt;
    work_next = work;
    if (!bypass_q) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        idx = cnt + 2'(k);
        work_next[32*idx +: 32] = inv_col(work[32*idx +: 32]);
      end
    end
  end

  // Control FSM: capture in IDLE, walk columns in RUN, hold result in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      cnt       <= '0;
      bypass_q  <= 1'b0;
      out_valid <= 1'b0;
      out_state <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            work     <= in_state ^ in_key;
            bypass_q <= in_bypass;
            cnt      <= '0;
            if (in_bypass) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_state <= in_state ^ in_key;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          work <= work_next;
          cnt  <= cnt_sum[1:0];
          if (cnt_sum[2]) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_state <= work_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
